fir_mac_sequencer: RTL and testbench

//  Time-multiplexes one shared combinational add/multiply ALU to compute a TAPS-tap FIR output per input sample.

---
 rtl/fir_mac_sequencer.sv | 96 +++++++++
 tb/tb_fir_mac_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - TAPS-tap FIR sequencer driving one shared external multiply/add ALU
module fir_mac_sequencer #(
  parameter int N    = 16,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_wdata,
  output logic          busy,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic          alu_sel,
  input  logic [31:0]   alu_out
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  x [TAPS];
  logic [N-1:0]  c [TAPS];
  logic [31:0]   acc;
  logic [AW-1:0] k;
  logic          in_fire;
  logic          mac_last;

  assign in_fire  = in_valid && in_ready;
  assign mac_last = (k == AW'(TAPS - 1));
  // Accumulation is done here, so the ALU only ever multiplies.
  assign alu_sel  = 1'b1;
  assign out_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        alu_a = x[k];
        alu_b = c[k];
        if (mac_last) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
      acc <= '0;
      k   <= '0;
    end else begin
      // A write in the handshake cycle lands before MAC reads it.
      if (coef_we && state == IDLE && 32'(coef_addr) < TAPS)
        c[coef_addr] <= coef_wdata;
      if (in_fire) begin
        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= in_data;
        acc  <= '0;
        k    <= '0;
      end else if (state == MAC) begin
        acc <= acc + alu_out;
        if (!mac_last) k <= k + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed and randomized bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
  localparam int N    = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [N-1:0]  coef_wdata = '0;
  logic          busy;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic          alu_sel;
  logic [31:0]   alu_out;

  logic signed [31:0] ea, eb;
  logic [15:0]        s16;

  int ncomp = 0;
  int nfail = 0;

  logic signed [15:0] mx [TAPS];
  logic signed [15:0] mc [TAPS];

  fir_mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External ALU: signed multiply, or N-bit truncating add sign-extended.
  assign ea      = $signed(alu_a);
  assign eb      = $signed(alu_b);
  assign s16     = alu_a + alu_b;
  assign alu_out = alu_sel ? ea * eb : {{16{s16[15]}}, s16};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  function automatic logic [31:0] model_push(input logic [15:0] d);
    longint     s = 0;
    logic [63:0] u;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    for (int i = 0; i < TAPS; i++) s += longint'(mx[i]) * longint'(mc[i]);
    u = s;
    return u[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = '0;
      mc[i] = '0;
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [15:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    mc[a] = v;
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic send(input logic [15:0] din, input int hold, input bit busy_wr,
                      input bit sim_wr, input logic [AW-1:0] sa, input logic [15:0] sv);
    logic [31:0] exp;
    int          lat;
    chk1("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_data = din;
    if (sim_wr) begin
      coef_we = 1'b1; coef_addr = sa; coef_wdata = sv;
      mc[sa] = sv;
    end
    exp = model_push(din);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0; in_data = 16'($urandom);
    chk1("busy_mac", busy, 1'b1);
    chk1("in_ready_mac", in_ready, 1'b0);
    if (busy_wr) begin
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd9;
    end
    while (!out_valid && lat < 4 * TAPS) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      coef_we = 1'b0;
    end
    chk("latency", 32'(lat), 32'(TAPS + 1));
    chk("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, exp);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk1("post_valid", out_valid, 1'b0);
    chk1("post_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk1("rst_alu_sel", alu_sel, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse response through coefficients 1..8.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'(i + 1));
    send(16'd1, 0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < TAPS; i++) send(16'd0, 0, 1'b0, 1'b0, '0, '0);

    // Signed products.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'd0);
    write_coef('0, 16'hFFFD);
    send(16'hFFFB, 0, 1'b0, 1'b0, '0, '0);
    write_coef('0, 16'h8000);
    send(16'h7FFF, 0, 1'b0, 1'b0, '0, '0);

    // Accumulator wrap modulo 2^32.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, 0, 1'b0, 1'b0, '0, '0);

    // Backpressure for 5 cycles.
    send(16'h0123, 5, 1'b0, 1'b0, '0, '0);

    // Write during MAC is dropped; write in IDLE and same-cycle write are used.
    send(16'h0042, 0, 1'b1, 1'b0, '0, '0);
    send(16'h0007, 0, 1'b0, 1'b0, '0, '0);
    write_coef('0, 16'd9);
    send(16'h0011, 0, 1'b0, 1'b0, '0, '0);
    send(16'h0013, 0, 1'b0, 1'b1, AW'(3), 16'hFF00);

    // Reset mid-MAC aborts the sample and clears history and coefficients.
    in_valid = 1'b1; in_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    write_coef('0, 16'd1);
    write_coef(AW'(1), 16'd2);
    send(16'd1, 0, 1'b0, 1'b0, '0, '0);
    send(16'd0, 0, 1'b0, 1'b0, '0, '0);

    // Randomized samples, coefficients, writes and backpressure.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) write_coef(AW'($urandom), 16'($urandom));
      send(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), AW'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
